// File: rtl/alu_ctrl_sequencer_if.sv
// Control/memory bundle between the ALU control sequencer (master) and
// the instruction memory plus datapath control inputs (slave).
interface alu_ctrl_sequencer_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned IW    = 32
);
  logic             iRun;
  logic [IW-1:0]    iMemData;
  logic             iMemValid;
  logic             oPC_nRst;
  logic             oPC_en;
  logic             oPC_jmp;
  logic             oMUX_MAP;
  logic [3:0]       oRF_AddrA;
  logic [3:0]       oRF_AddrB;
  logic [3:0]       oRF_AddrC;
  logic             oRF_Write;
  logic             oRA_en;
  logic             oRB_en;
  logic             oRZH_en;
  logic             oRZL_en;
  logic             oRAS_en;
  logic             oRWB_en;
  logic [3:0]       oALU_Ctrl;
  logic             oMUX_BIS;
  logic             oMUX_RZHS;
  logic             oMUX_WBM;
  logic             oMUX_WBP;
  logic             oMUX_ASS;
  logic [IW-1:0]    oImm32;
  logic             oBusy;
  logic             oDone;
  logic             oIllegal;
  logic [CNT_W-1:0] oInstrCount;

  modport master (
    input  iRun, iMemData, iMemValid,
    output oPC_nRst, oPC_en, oPC_jmp, oMUX_MAP, oRF_AddrA, oRF_AddrB, oRF_AddrC, oRF_Write,
           oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en, oRWB_en, oALU_Ctrl, oMUX_BIS, oMUX_RZHS,
           oMUX_WBM, oMUX_WBP, oMUX_ASS, oImm32, oBusy, oDone, oIllegal, oInstrCount
  );

  modport slave (
    output iRun, iMemData, iMemValid,
    input  oPC_nRst, oPC_en, oPC_jmp, oMUX_MAP, oRF_AddrA, oRF_AddrB, oRF_AddrC, oRF_Write,
           oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en, oRWB_en, oALU_Ctrl, oMUX_BIS, oMUX_RZHS,
           oMUX_WBM, oMUX_WBP, oMUX_ASS, oImm32, oBusy, oDone, oIllegal, oInstrCount
  );
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// Moore sequencer for register-to-register ALU instructions (FETCH..WBW).
// Define CTRL_SEQ_IMM_EN to add immediate-ALU ops (op[4:3] = 2'b10).
module alu_ctrl_sequencer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned IW    = 32
) (
  input logic                  iClk,
  input logic                  iRst,
  alu_ctrl_sequencer_if.master bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StWbl    = 3'd4;
  localparam logic [2:0] StWbw    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_released_q, pc_released_d;

  logic [4:0]    op;
  logic [3:0]    ra, rb, rc;
  logic          is_imm;
  logic          is_illegal;
  logic [3:0]    alu_op;
  logic [IW-1:0] imm_ext;

  assign op = ir_q[31:27];
  assign ra = ir_q[26:23];
  assign rb = ir_q[22:19];
  assign rc = ir_q[18:15];

`ifdef CTRL_SEQ_IMM_EN
  assign is_imm  = (op[4:3] == 2'b10);
  assign imm_ext = {{(IW-19){ir_q[18]}}, ir_q[18:0]};
`else
  logic unused_ir;
  assign is_imm    = 1'b0;
  assign imm_ext   = '0;
  assign unused_ir = ^ir_q[14:0];
`endif

  assign is_illegal = op[4] & ~is_imm;
  assign alu_op     = is_imm ? {1'b0, op[2:0]} : op[3:0];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q       <= StIdle;
      ir_q          <= '0;
      cnt_q         <= '0;
      pc_released_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      cnt_q         <= cnt_d;
      pc_released_q <= pc_released_d;
    end
  end

  // iRun is only looked at in IDLE, on the illegal exit and at the end of WBW.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    cnt_d         = cnt_q;
    pc_released_d = pc_released_q;
    case (state_q)
      StIdle: begin
        if (bus.iRun) begin
          state_d       = StFetch;
          pc_released_d = 1'b1;
        end
      end
      StFetch: begin
        if (bus.iMemValid) begin
          ir_d    = bus.iMemData;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_illegal) state_d = bus.iRun ? StFetch : StIdle;
        else            state_d = StExec;
      end
      StExec: state_d = StWbl;
      StWbl:  state_d = StWbw;
      StWbw: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = bus.iRun ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.oPC_nRst    = pc_released_q;
    bus.oPC_en      = 1'b0;
    bus.oPC_jmp     = 1'b0;
    bus.oMUX_MAP    = 1'b0;
    bus.oRF_AddrA   = 4'd0;
    bus.oRF_AddrB   = 4'd0;
    bus.oRF_AddrC   = 4'd0;
    bus.oRF_Write   = 1'b0;
    bus.oRA_en      = 1'b0;
    bus.oRB_en      = 1'b0;
    bus.oRZH_en     = 1'b0;
    bus.oRZL_en     = 1'b0;
    bus.oRAS_en     = 1'b0;
    bus.oRWB_en     = 1'b0;
    bus.oALU_Ctrl   = 4'd0;
    bus.oMUX_BIS    = 1'b0;
    bus.oMUX_RZHS   = 1'b0;
    bus.oMUX_WBM    = 1'b0;
    bus.oMUX_WBP    = 1'b0;
    bus.oMUX_ASS    = 1'b0;
    bus.oImm32      = '0;
    bus.oBusy       = (state_q != StIdle);
    bus.oDone       = 1'b0;
    bus.oIllegal    = 1'b0;
    bus.oInstrCount = cnt_q;
    case (state_q)
      StFetch: begin
        bus.oMUX_MAP = 1'b1;
        bus.oPC_jmp  = 1'b1;
        // PC advances only on the cycle the instruction word is captured.
        bus.oPC_en   = bus.iMemValid;
      end
      StDecode: begin
        bus.oRF_AddrA = rb;
        bus.oRF_AddrB = rc;
        bus.oRA_en    = 1'b1;
        bus.oRB_en    = ~is_imm;
        bus.oMUX_BIS  = is_imm;
        bus.oImm32    = is_imm ? imm_ext : '0;
        bus.oIllegal  = is_illegal;
      end
      StExec: begin
        bus.oALU_Ctrl = alu_op;
        bus.oRZH_en   = 1'b1;
        bus.oRZL_en   = 1'b1;
        bus.oMUX_BIS  = is_imm;
        bus.oImm32    = is_imm ? imm_ext : '0;
      end
      StWbl: begin
        bus.oRWB_en   = 1'b1;
        bus.oALU_Ctrl = alu_op;
      end
      StWbw: begin
        bus.oRF_AddrC = ra;
        bus.oRF_Write = 1'b1;
        bus.oDone     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Randomized bench for alu_ctrl_sequencer with an instruction-level reference model.
module tb_alu_ctrl_sequencer;

  localparam int unsigned CntW = 2;
  localparam int unsigned Iw   = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_model = 0;
  bit   pc_rel_model = 1'b0;
  bit   ends_idle;

  alu_ctrl_sequencer_if #(.CNT_W(CntW), .IW(Iw)) bus ();

  alu_ctrl_sequencer #(.CNT_W(CntW), .IW(Iw)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic any_out;
  assign any_out = |{bus.oPC_nRst, bus.oPC_en, bus.oPC_jmp, bus.oMUX_MAP, bus.oRF_AddrA,
                     bus.oRF_AddrB, bus.oRF_AddrC, bus.oRF_Write, bus.oRA_en, bus.oRB_en,
                     bus.oRZH_en, bus.oRZL_en, bus.oRAS_en, bus.oRWB_en, bus.oALU_Ctrl,
                     bus.oMUX_BIS, bus.oMUX_RZHS, bus.oMUX_WBM, bus.oMUX_WBP, bus.oMUX_ASS,
                     bus.oImm32, bus.oBusy, bus.oDone, bus.oIllegal, bus.oInstrCount};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit f_is_imm(input logic [4:0] op);
`ifdef CTRL_SEQ_IMM_EN
    return op[4:3] == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  // From IDLE at a falling edge: raise iRun, land in FETCH one cycle later.
  task automatic start_run();
    check_eq("idle_busy", 64'(bus.oBusy), 64'(0));
    check_eq("idle_pc_nrst", 64'(bus.oPC_nRst), 64'(pc_rel_model));
    bus.iRun = 1'b1;
    @(negedge clk);
    pc_rel_model = 1'b1;
    check_eq("start_busy", 64'(bus.oBusy), 64'(1));
    check_eq("start_pc_nrst", 64'(bus.oPC_nRst), 64'(1));
    check_eq("start_map", 64'(bus.oMUX_MAP), 64'(1));
  endtask

  // Entered at a falling edge in FETCH; returns at a falling edge in FETCH or IDLE.
  task automatic run_instr(input logic [31:0] instr, input int wait_cyc, input bit run_after,
                           input bit rst_in_wbl, output bit idle_out);
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc, alu;
    logic [31:0] immv;
    bit          imm, ill;
    op   = instr[31:27];
    ra   = instr[26:23];
    rb   = instr[22:19];
    rc   = instr[18:15];
    imm  = f_is_imm(op);
    ill  = op[4] && !imm;
    alu  = imm ? {1'b0, op[2:0]} : op[3:0];
    immv = imm ? {{13{instr[18]}}, instr[18:0]} : 32'd0;

    for (int i = 0; i < wait_cyc; i++) begin
      bus.iMemValid = 1'b0;
      bus.iMemData  = $urandom;
      #1;
      check_eq("fetch_wait_pc_en", 64'(bus.oPC_en), 64'(0));
      check_eq("fetch_wait_busy", 64'(bus.oBusy), 64'(1));
      check_eq("fetch_wait_jmp", 64'(bus.oPC_jmp), 64'(1));
      @(negedge clk);
    end
    bus.iMemValid = 1'b1;
    bus.iMemData  = instr;
    #1;
    check_eq("fetch_pc_en", 64'(bus.oPC_en), 64'(1));
    check_eq("fetch_map", 64'(bus.oMUX_MAP), 64'(1));

    @(negedge clk);
    bus.iMemValid = 1'b0;
    bus.iMemData  = $urandom;
    bus.iRun      = run_after;
    #1;
    check_eq("dec_pc_en", 64'(bus.oPC_en), 64'(0));
    check_eq("dec_addr_a", 64'(bus.oRF_AddrA), 64'(rb));
    check_eq("dec_addr_b", 64'(bus.oRF_AddrB), 64'(rc));
    check_eq("dec_ra_en", 64'(bus.oRA_en), 64'(1));
    check_eq("dec_rb_en", 64'(bus.oRB_en), 64'(!imm));
    check_eq("dec_mux_bis", 64'(bus.oMUX_BIS), 64'(imm));
    check_eq("dec_imm32", 64'(bus.oImm32), 64'(immv));
    check_eq("dec_illegal", 64'(bus.oIllegal), 64'(ill));
    check_eq("dec_rf_write", 64'(bus.oRF_Write), 64'(0));
    check_eq("dec_rzh_en", 64'(bus.oRZH_en), 64'(0));

    if (ill) begin
      @(negedge clk);
      check_eq("ill_after_pulse", 64'(bus.oIllegal), 64'(0));
      check_eq("ill_no_rzh", 64'(bus.oRZH_en), 64'(0));
      check_eq("ill_no_write", 64'(bus.oRF_Write), 64'(0));
      check_eq("ill_busy", 64'(bus.oBusy), 64'(run_after));
      check_eq("ill_count", 64'(bus.oInstrCount), 64'(cnt_model));
      idle_out = !run_after;
      return;
    end

    @(negedge clk);
    check_eq("exec_alu", 64'(bus.oALU_Ctrl), 64'(alu));
    check_eq("exec_rzh_en", 64'(bus.oRZH_en), 64'(1));
    check_eq("exec_rzl_en", 64'(bus.oRZL_en), 64'(1));
    check_eq("exec_rwb_en", 64'(bus.oRWB_en), 64'(0));
    check_eq("exec_mux_bis", 64'(bus.oMUX_BIS), 64'(imm));
    check_eq("exec_imm32", 64'(bus.oImm32), 64'(immv));
    check_eq("exec_addr_a", 64'(bus.oRF_AddrA), 64'(0));
    check_eq("exec_rf_write", 64'(bus.oRF_Write), 64'(0));

    @(negedge clk);
    check_eq("wbl_rwb_en", 64'(bus.oRWB_en), 64'(1));
    check_eq("wbl_alu", 64'(bus.oALU_Ctrl), 64'(alu));
    check_eq("wbl_rzh_en", 64'(bus.oRZH_en), 64'(0));
    check_eq("wbl_imm32", 64'(bus.oImm32), 64'(0));
    check_eq("wbl_rf_write", 64'(bus.oRF_Write), 64'(0));

    if (rst_in_wbl) begin
      #2;
      rst      = 1'b1;
      bus.iRun = 1'b0;
      #1;
      check_eq("rst_all_zero", 64'(any_out), 64'(0));
      check_eq("rst_pc_nrst", 64'(bus.oPC_nRst), 64'(0));
      @(negedge clk);
      check_eq("rst_no_write", 64'(bus.oRF_Write), 64'(0));
      check_eq("rst_count", 64'(bus.oInstrCount), 64'(0));
      rst          = 1'b0;
      cnt_model    = 0;
      pc_rel_model = 1'b0;
      idle_out     = 1'b1;
      return;
    end

    @(negedge clk);
    check_eq("wbw_addr_c", 64'(bus.oRF_AddrC), 64'(ra));
    check_eq("wbw_rf_write", 64'(bus.oRF_Write), 64'(1));
    check_eq("wbw_done", 64'(bus.oDone), 64'(1));
    check_eq("wbw_alu", 64'(bus.oALU_Ctrl), 64'(0));
    check_eq("wbw_rwb_en", 64'(bus.oRWB_en), 64'(0));

    @(negedge clk);
    cnt_model = (cnt_model + 1) % (1 << CntW);
    check_eq("ret_count", 64'(bus.oInstrCount), 64'(cnt_model));
    check_eq("ret_done", 64'(bus.oDone), 64'(0));
    check_eq("ret_rf_write", 64'(bus.oRF_Write), 64'(0));
    check_eq("ret_busy", 64'(bus.oBusy), 64'(run_after));
    check_eq("ret_pc_nrst", 64'(bus.oPC_nRst), 64'(1));
    idle_out = !run_after;
  endtask

  initial begin
    logic [31:0] instr;
    bit          run_after, rst_in;

    rst           = 1'b1;
    bus.iRun      = 1'b0;
    bus.iMemValid = 1'b0;
    bus.iMemData  = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_all_zero", 64'(any_out), 64'(0));
    check_eq("reset_count", 64'(bus.oInstrCount), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_hold_busy", 64'(bus.oBusy), 64'(0));
    start_run();

    // Directed cases: zero-wait, wait states, illegal, iRun drop, reset in WBL.
    run_instr({5'b00101, 4'd4, 4'd3, 4'd7, 15'd0}, 0, 1'b1, 1'b0, ends_idle);
    run_instr({5'b01010, 4'd9, 4'd1, 4'd15, 15'h1234}, 3, 1'b1, 1'b0, ends_idle);
    run_instr({5'b11000, 4'd2, 4'd5, 4'd6, 15'd0}, 0, 1'b1, 1'b0, ends_idle);
    run_instr({5'b00011, 4'd8, 4'd2, 4'd10, 15'd0}, 1, 1'b0, 1'b0, ends_idle);
    start_run();
    run_instr({5'b00110, 4'd12, 4'd0, 4'd1, 15'd0}, 0, 1'b1, 1'b1, ends_idle);
    start_run();

    // Four retirements from a cleared counter wrap a 2-bit count back to 0.
    for (int i = 0; i < 4; i++) begin
      instr        = $urandom;
      instr[31]    = 1'b0;
      run_instr(instr, 0, 1'b1, 1'b0, ends_idle);
    end
    check_eq("count_wrap", 64'(bus.oInstrCount), 64'(0));

`ifdef CTRL_SEQ_IMM_EN
    run_instr({5'b10001, 4'd3, 4'd6, 19'h7FFFF}, 0, 1'b1, 1'b0, ends_idle);
`endif

    for (int i = 0; i < 60; i++) begin
      instr     = $urandom;
      run_after = ($urandom_range(0, 4) != 0);
      rst_in    = ($urandom_range(0, 12) == 0);
      run_instr(instr, int'($urandom_range(0, 3)), run_after, rst_in, ends_idle);
      if (ends_idle) start_run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Control-unit sequencer that issues the datapath control signals for register-to-register ALU instructions.
- Fetch, decode, execute, write-back latch and register-file write each take one state.
- Sits between instruction memory and the Datapath module. Its outputs connect one-to-one to the Datapath control inputs of the same name, with prefix i replaced by o.
- Owns the instruction register and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- IW, 32, instruction and Imm32 width

Ports:
- iClk  in  1  clock, rising edge
- iRst  in  1  asynchronous reset, active-high
- iRun  in  1  level; high = sequence instructions, low = stop after current instruction
- iMemData  in  32  instruction word from memory
- iMemValid  in  1  iMemData valid this cycle
- oPC_nRst  out  1  PC reset release, active low
- oPC_en, oPC_jmp, oMUX_MAP  out  1 each  PC control
- oRF_AddrA, oRF_AddrB, oRF_AddrC  out  4 each  register-file addresses
- oRF_Write  out  1  register-file write
- oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en, oRWB_en  out  1 each  register enables
- oALU_Ctrl  out  4  ALU operation
- oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_WBP, oMUX_ASS  out  1 each  mux selects
- oImm32  out  32  immediate to datapath
- oBusy  out  1  high in any state except IDLE
- oDone  out  1  one-cycle pulse in WBW
- oIllegal  out  1  one-cycle pulse on undecodable opcode
- oInstrCount  out  CNT_W  retired instructions, wraps to 0

Behaviour:
- Instruction fields:
  - op = IR[31:27], Ra = IR[26:23] (destination), Rb = IR[22:19], Rc = IR[18:15].
  - R-type: op[4] = 0; oALU_Ctrl = op[3:0].
- States: IDLE, FETCH, DECODE, EXEC, WBL, WBW.
- Outputs are Moore, decoded from the state register and IR. Every output is 0 unless listed for the state below.
- Reset (async): state = IDLE, IR = 0, counter = 0, pc_released = 0, all outputs 0 (oPC_nRst = 0).
- IDLE: iRun = 1 -> FETCH and set pc_released. oPC_nRst = pc_released in every state.
- FETCH: oMUX_MAP = 1, oPC_jmp = 1.
  - iMemValid = 0: stay; oPC_en = 0.
  - iMemValid = 1: oPC_en = 1 this cycle only; IR <= iMemData; -> DECODE.
- DECODE: oRF_AddrA = Rb, oRF_AddrB = Rc, oRA_en = oRB_en = 1, oMUX_BIS = 0.
  - op[4] = 1 (illegal): pulse oIllegal; -> FETCH if iRun, else IDLE. No write occurs and the counter is unchanged.
  - Otherwise -> EXEC.
- EXEC: oALU_Ctrl = op[3:0], oRZH_en = oRZL_en = 1, oMUX_RZHS = oMUX_ASS = oMUX_WBM = oMUX_WBP = 0. -> WBL.
- WBL: oRWB_en = 1; oALU_Ctrl held. -> WBW.
- WBW: oRF_AddrC = Ra, oRF_Write = 1, oDone = 1; counter += 1 (modulo 2^CNT_W). -> FETCH if iRun, else IDLE.
- Latency: 5 cycles per instruction with zero-wait memory. Each FETCH wait cycle adds 1 cycle.
- Sampling of iRun:
  - iRun is sampled only in IDLE, at the end of WBW, and on the illegal-opcode exit from DECODE.
  - Deasserting iRun mid-instruction lets that instruction complete.
- oBusy = (state != IDLE).
- Register addresses hold their last value only within their own state and read 0 elsewhere.
- iRst asserted mid-instruction:
  - Immediate return to IDLE with all outputs 0; any pending write is lost.
  - pc_released clears, so the PC is held in reset until the next start.

Optional Feature:
- Macro CTRL_SEQ_IMM_EN.
- Defined:
  - op[4:3] = 2'b10 is immediate-ALU; oALU_Ctrl = {1'b0, op[2:0]}.
  - DECODE: oMUX_BIS = 1, oRB_en = 0, oImm32 = sign-extended IR[18:0].
  - oImm32 and oMUX_BIS hold through EXEC.
  - op[4:3] = 2'b11 is illegal.
- Undefined: every op[4] = 1 is illegal; oImm32 is tied to 0; oMUX_BIS is tied to 0.

Test Plan:
- Reset, then iRun = 1 with iMemValid = 1 and IR = {5'b00101, 4'd4, 4'd3, 4'd7, 15'd0} -> FETCH, DECODE, EXEC, WBL, WBW on consecutive cycles.
  - DECODE: AddrA = 3, AddrB = 7.
  - EXEC: oALU_Ctrl = 4'b0101.
  - WBW: AddrC = 4, RF_Write = 1, oDone = 1; oInstrCount = 1.
- iMemValid held low 3 cycles in FETCH -> oPC_en stays 0 and the state stays FETCH. On valid: oPC_en = 1 for exactly one cycle; total instruction time is 8 cycles.
- Illegal opcode 5'b11000 -> oIllegal pulses in DECODE; RZH_en, RWB_en and RF_Write never assert; count unchanged.
- iRun dropped during EXEC -> instruction completes (oDone = 1), then IDLE with oBusy = 0. oPC_nRst stays 1.
- iRst pulsed during WBL -> all outputs 0 and oPC_nRst = 0 on the same edge; no RF_Write; count = 0.
- Counter wrap with CNT_W = 2 -> after 4 instructions oInstrCount = 0. With CTRL_SEQ_IMM_EN and op = 5'b10001, IR[18:0] = 19'h7FFFF -> oImm32 = 32'hFFFFFFFF, oMUX_BIS = 1, oALU_Ctrl = 4'b0001.
